// File: rtl/mul_pkg.sv
// Shared constants and stage control record for the segmented pipelined adder.
package mul_pkg;

   localparam int unsigned WIDTH_DEF = 32;
   localparam int unsigned SEG_DEF   = 8;

   // Per-stage control record: valid bit, carry out of the segment just added,
   // and the operand sign bits needed for the final overflow decision.
   // The width-dependent parts of a stage (finished sum segments, residual
   // operand segments) shrink or grow per stage and live beside this record.
   typedef struct packed {
      logic valid;
      logic carry;
      logic a_msb;
      logic b_msb;
   } stage_ctl_t;

endpackage

// File: rtl/seg_adder_stage.sv
// Combinational SEG-bit adder slice with carry in and carry out.
module seg_adder_stage
   import mul_pkg::*;
#(
   parameter int unsigned SEG = SEG_DEF
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           cin,
   output logic [SEG-1:0] s,
   output logic           cout
);

   // One segment of the carry chain.
   always_comb begin
      {cout, s} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
   end

endmodule

// File: rtl/seg_pipe_adder.sv
// Pipelined adder that breaks the carry chain into WIDTH/SEG registered segments.
// Optional add/subtract input enabled by defining PIPE_ADD_SUB_EN.
module seg_pipe_adder
   import mul_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned SEG   = SEG_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef PIPE_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned NSEG = (SEG == 0) ? 1 : WIDTH / SEG;

   if (SEG == 0 || (WIDTH % SEG) != 0 || WIDTH == 0) begin : g_bad_cfg
      $error("seg_pipe_adder: SEG must be nonzero and divide WIDTH");
   end

   logic             adv;
   logic             accept;
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;
   logic             last_valid;

   // Global advance: the whole pipe moves unless a result is stuck at the output.
   always_comb begin
      adv      = !last_valid || out_ready;
      in_ready = adv;
      accept   = in_valid && adv;
`ifdef PIPE_ADD_SUB_EN
      b_eff    = sub ? ~b : b;
      cin_eff  = sub ? 1'b1 : cin;
`else
      b_eff    = b;
      cin_eff  = cin;
`endif
   end

   for (genvar k = 0; k < NSEG; k++) begin : g_stage
      // Operand bits still unconsumed on entry, and sum bits finished on exit.
      localparam int unsigned IW = WIDTH - k * SEG;
      localparam int unsigned DW = (k + 1) * SEG;

      logic [IW-1:0]  in_a;
      logic [IW-1:0]  in_b;
      stage_ctl_t     ctl_in;
      stage_ctl_t     ctl_d;
      stage_ctl_t     ctl_q;
      logic [SEG-1:0] seg_sum;
      logic           seg_cout;
      logic [DW-1:0]  done_d;
      logic [DW-1:0]  done_q;

      if (k == 0) begin : g_src
         assign in_a   = a;
         assign in_b   = b_eff;
         assign ctl_in = '{valid: accept, carry: cin_eff,
                           a_msb: a[WIDTH-1], b_msb: b_eff[WIDTH-1]};
         assign done_d = seg_sum;
      end else begin : g_src
         assign in_a   = g_stage[k-1].g_res.res_a_q;
         assign in_b   = g_stage[k-1].g_res.res_b_q;
         assign ctl_in = g_stage[k-1].ctl_q;
         assign done_d = {seg_sum, g_stage[k-1].done_q};
      end

      seg_adder_stage #(
         .SEG (SEG)
      ) u_add (
         .a    (in_a[SEG-1:0]),
         .b    (in_b[SEG-1:0]),
         .cin  (ctl_in.carry),
         .s    (seg_sum),
         .cout (seg_cout)
      );

      // Forward the control record, replacing the carry with this segment's carry out.
      always_comb begin
         ctl_d       = ctl_in;
         ctl_d.carry = seg_cout;
      end

      // Stage register: valid clears asynchronously; everything holds on stall.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            ctl_q  <= '0;
            done_q <= '0;
         end else if (adv) begin
            ctl_q  <= ctl_d;
            done_q <= done_d;
         end
      end

      // Upper operand segments still waiting for later stages; absent in the last stage.
      if (IW > SEG) begin : g_res
         logic [IW-SEG-1:0] res_a_q;
         logic [IW-SEG-1:0] res_b_q;

         // Residual operand register, dropping the segment consumed here.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               res_a_q <= '0;
               res_b_q <= '0;
            end else if (adv) begin
               res_a_q <= in_a[IW-1:SEG];
               res_b_q <= in_b[IW-1:SEG];
            end
         end
      end
   end

   // Output view of the final stage; overflow is decided from the stored sign bits.
   always_comb begin
      last_valid = g_stage[NSEG-1].ctl_q.valid;
      out_valid  = last_valid;
      sum        = g_stage[NSEG-1].done_q;
      cout       = g_stage[NSEG-1].ctl_q.carry;
      ovf        = (g_stage[NSEG-1].ctl_q.a_msb == g_stage[NSEG-1].ctl_q.b_msb) &&
                   (g_stage[NSEG-1].done_q[WIDTH-1] != g_stage[NSEG-1].ctl_q.a_msb);
   end

endmodule

// File: doc/seg_pipe_adder.md
SEG_PIPE_ADDER -- requirements
Module: seg_pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and sum width in bits.
REQ-002 SHALL have parameter SEG, default 8, carry-chain segment width in bits; WIDTH SHALL be a multiple of SEG.
REQ-003 SHALL derive NSEG = WIDTH/SEG, which is the pipeline depth.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  operands are presented.
REQ-007 in_ready  output  1  block accepts operands this cycle.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry-in.
REQ-011 out_valid  output  1  result is presented.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-014 cout  output  1  carry out of bit WIDTH-1.
REQ-015 ovf  output  1  two's-complement signed overflow.

Function
REQ-016 SHALL compute {cout,sum} = a + b + cin (with B replaced per REQ-031 when subtracting).
REQ-017 Stage k (k = 0..NSEG-1) SHALL add segment k of the operands plus the registered carry from stage k-1 (stage 0 uses cin).
REQ-018 Each stage SHALL register: its sum segment, the already-finished lower segments, the unconsumed upper operand segments, its carry, and a valid bit.
REQ-019 Latency SHALL be exactly NSEG cycles from the accepting edge to out_valid, when no stall occurs.
REQ-020 Throughput SHALL be one transaction per cycle when out_ready=1.
REQ-021 Global advance enable SHALL be adv = !out_valid || out_ready; in_ready SHALL equal adv.
REQ-022 Operands SHALL be accepted only when in_valid && in_ready.
REQ-023 When adv=0, all stage registers SHALL hold, and sum/cout/ovf/out_valid SHALL be stable.
REQ-024 When adv=1 and no operands are accepted, a bubble (valid=0) SHALL enter stage 0.
REQ-025 A result SHALL be consumed on out_valid && out_ready; transactions SHALL never be dropped, duplicated or reordered.
REQ-026 ovf SHALL be (a_msb == b_eff_msb) && (sum_msb != a_msb), computed in the final stage.
REQ-027 When NSEG=1, the block SHALL degenerate to a single registered adder with latency 1.

Reset
REQ-028 While rst=1, all valid bits SHALL clear asynchronously, so out_valid=0 and in-flight transactions are discarded.
REQ-029 While rst=1, sum, cout and ovf SHALL be 0.
REQ-030 After rst deasserts, in_ready SHALL be 1 on the first cycle.

Configuration
REQ-031 With PIPE_ADD_SUB_EN defined, the block SHALL have input sub (1 bit, sampled with a and b):
- sub=1: computes a + ~b + 1, and cin is ignored.
- borrow is signalled as cout=0.
REQ-032 Without PIPE_ADD_SUB_EN, the sub port SHALL be absent and the block SHALL add only.

Structure
REQ-033 Shared package mul_pkg SHALL hold the default WIDTH/SEG constants and the stage-register struct typedef (seg sum, carry, valid, residual operands).
REQ-034 One sub-module, seg_adder_stage (parameter SEG, combinational SEG-bit adder with carry in/out), SHALL be instantiated NSEG times.
REQ-035 The block SHALL be legal for any WIDTH/SEG combination where SEG divides WIDTH; an elaboration-time check SHALL fail otherwise.

Verification (WIDTH=32, SEG=8, so latency 4)
REQ-036 a=0xFFFFFFFF, b=1, cin=0 -> sum=0x00000000, cout=1, ovf=0 on the 4th cycle after acceptance.
REQ-037 a=0x7FFFFFFF, b=1, cin=0 -> sum=0x80000000, cout=0, ovf=1.
REQ-038 Four back-to-back transactions with out_ready=0 from the first out_valid:
- in_ready drops and outputs hold for 10 cycles.
- on releasing out_ready, the four results emerge in order on consecutive cycles.
REQ-039 rst asserted with 3 transactions in flight:
- out_valid=0 immediately.
- no result appears after deassertion unless new operands are accepted.
REQ-040 With PIPE_ADD_SUB_EN: a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0.
REQ-041 WIDTH=32, SEG=32: random operands at one per cycle -> matching results with latency 1.
